tt_sweep_checker: RTL and testbench
===================================

Name: tt_sweep_checker

Overview:
- Synthesisable, parametrised successor to hand-written vector-by-vector combinational testbenches.
- Sweeps all 2^N input vectors into a combinational DUT and holds each vector for a programmable settle time.
- Samples the DUT outputs and compares them against a truth table supplied as a parameter.
- Reports mismatch count, first failing vector, per-vector mismatch pulses and a pass/done summary; usable in simulation benches and on-chip self-test.

Parameters:
- N, 3, DUT input width (1..16)
- M, 1, DUT output width (1..32)
- SETTLE, 1, extra cycles each vector is held before sampling (0..255)
- EXPECTED, 8'h31, expected-output table, M*2^N bits; vector v's expected word is EXPECTED[v*M +: M]. The default encodes y=1 for vectors 000, 100 and 101 only.
- STOP_ON_FAIL, 0, when 1 the sweep terminates at the first mismatch

Ports:
- clk  input  1  rising-edge clock
- reset_n  input  1  synchronous active-low reset
- start  input  1  single-cycle request to begin a sweep
- dut_in  output  N  vector currently applied to the DUT
- dut_out  input  M  DUT response
- busy  output  1  high while a sweep is in progress
- done  output  1  high from sweep end until the next start or reset
- pass  output  1  done && err_count==0
- err_count  output  N+1  number of mismatching vectors
- first_fail_valid  output  1  high once any mismatch has been recorded
- first_fail_vec  output  N  first mismatching vector
- mismatch  output  1  one-cycle pulse on each mismatching sample
- mismatch_vec  output  N  vector associated with the current mismatch pulse

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-low (reset_n). All state updates on the rising edge of clk; reset is sampled only at that edge.
- Reset (reset_n=0 at an edge, including mid-sweep):
  - state=IDLE
  - dut_in, err_count, first_fail_vec, mismatch_vec = 0
  - busy, done, pass, first_fail_valid, mismatch = 0
  - Reset has priority over start.
- FSM has three states: IDLE, RUN, DONE.
- IDLE:
  - start=1 -> RUN; busy=1; vec=0; settle_cnt=0; err_count cleared; first_fail_valid cleared.
- RUN:
  - dut_in = vec; each vector is held SETTLE+1 cycles.
  - While settle_cnt<SETTLE, settle_cnt increments each cycle.
  - On the cycle where settle_cnt==SETTLE (the sample cycle), dut_out is compared with EXPECTED[vec*M +: M] using case inequality, so X/Z on any bit counts as a mismatch.
  - On a mismatch:
    - The mismatch pulse is registered (high the next cycle) with mismatch_vec=vec.
    - err_count increments.
    - If first_fail_valid=0: set it, and first_fail_vec=vec.
  - After the sample cycle:
    - If vec==2^N-1, or (STOP_ON_FAIL=1 and a mismatch occurred): -> DONE.
    - Otherwise vec+1, settle_cnt=0.
  - The vector counter is N+1 bits internally, so there is no wrap-around ambiguity at 2^N-1.
- DONE:
  - busy=0, done=1; pass recomputed from the final err_count.
  - dut_in holds the last applied vector.
  - start=1 -> re-enter RUN exactly as from IDLE; done drops the same edge.
- start while busy is ignored.
- Timing:
  - Full sweep, first RUN cycle to the done-high cycle: 2^N*(SETTLE+1) cycles.
  - With default parameters: 16 cycles.
- Width: err_count max is 2^N and fits in N+1 bits, so no saturation is needed.

Test Plan:
- Correct DUT (y = ~a&~b&~c | a&~b&~c | a&~b&c), defaults, start pulse:
  - dut_in steps 0..7, each held 2 cycles.
  - done high 16 cycles after the first RUN cycle; pass=1, err_count=0, first_fail_valid=0, no mismatch pulses.
- DUT output stuck at 0, defaults:
  - Mismatch pulses for vectors 0, 4, 5.
  - err_count=3, first_fail_vec=0, pass=0.
- DUT also outputs 1 for vector 6 (110), all else correct:
  - err_count=1, first_fail_vec=6, one mismatch pulse with mismatch_vec=6.
- Same faulty DUT with STOP_ON_FAIL=1:
  - Sweep ends after vector 6's sample; done high 14 cycles after the first RUN cycle.
  - dut_in holds 6; err_count=1.
- reset_n low for one edge at vector 3 mid-sweep, then start reasserted:
  - All outputs are 0 the cycle after reset.
  - The new sweep begins at vector 0 and repeats the first scenario's results.
- start held high for the entire sweep, then again in DONE:
  - The held start does not restart the sweep mid-run.
  - In DONE, start clears done and err_count and the sweep restarts at vector 0.
- SETTLE=0, N=4, M=2, random EXPECTED against a model DUT:
  - Sweep takes 16 cycles; err_count matches the reference model's mismatch count.

Source files
------------

// File: rtl/tt_sweep_checker.sv
// Exhaustive sweep checker: drives every N-bit vector into a combinational DUT,
// compares each response with a parameterised truth table and summarises the result.
module tt_sweep_checker #(
    parameter int                   N            = 3,
    parameter int                   M            = 1,
    parameter int                   SETTLE       = 1,
    parameter logic [M*(2**N)-1:0]  EXPECTED     = 8'h31,
    parameter bit                   STOP_ON_FAIL = 1'b0
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         start,
    output logic [N-1:0] dut_in,
    input  logic [M-1:0] dut_out,
    output logic         busy,
    output logic         done,
    output logic         pass,
    output logic [N:0]   err_count,
    output logic         first_fail_valid,
    output logic [N-1:0] first_fail_vec,
    output logic         mismatch,
    output logic [N-1:0] mismatch_vec
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [N:0] LAST_VEC    = {1'b0, {N{1'b1}}};
    localparam logic [N:0] ONE_N1      = {{N{1'b0}}, 1'b1};
    localparam logic [7:0] SETTLE_LAST = 8'(SETTLE);

    state_t       state_reg, state_next;
    logic [N:0]   vec_reg, vec_next;
    logic [7:0]   settle_cnt_reg, settle_cnt_next;
    logic [N:0]   err_count_reg, err_count_next;
    logic         ffv_reg, ffv_next;
    logic [N-1:0] ffvec_reg, ffvec_next;
    logic         mismatch_reg, mismatch_next;
    logic [N-1:0] mismatch_vec_reg, mismatch_vec_next;

    logic [M-1:0] exp_table [2**N];
    logic [M-1:0] exp_word;
    logic         sample;
    logic         mis_hit;

    // Unpack the flat truth table into one word per vector.
    genvar gi;
    generate
        for (gi = 0; gi < 2**N; gi++) begin : g_exp
            assign exp_table[gi] = EXPECTED[gi*M +: M];
        end
    endgenerate

    assign exp_word = exp_table[vec_reg[N-1:0]];
    assign sample   = (settle_cnt_reg == SETTLE_LAST);
    // Case inequality so that an X/Z response is reported rather than masked.
    assign mis_hit  = (state_reg == RUN) && sample && (dut_out !== exp_word);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg        <= IDLE;
            vec_reg          <= '0;
            settle_cnt_reg   <= '0;
            err_count_reg    <= '0;
            ffv_reg          <= 1'b0;
            ffvec_reg        <= '0;
            mismatch_reg     <= 1'b0;
            mismatch_vec_reg <= '0;
        end else begin
            state_reg        <= state_next;
            vec_reg          <= vec_next;
            settle_cnt_reg   <= settle_cnt_next;
            err_count_reg    <= err_count_next;
            ffv_reg          <= ffv_next;
            ffvec_reg        <= ffvec_next;
            mismatch_reg     <= mismatch_next;
            mismatch_vec_reg <= mismatch_vec_next;
        end
    end

    always_comb begin
        state_next        = state_reg;
        vec_next          = vec_reg;
        settle_cnt_next   = settle_cnt_reg;
        err_count_next    = err_count_reg;
        ffv_next          = ffv_reg;
        ffvec_next        = ffvec_reg;
        mismatch_next     = 1'b0;
        mismatch_vec_next = mismatch_vec_reg;

        case (state_reg)
            IDLE, DONE: begin
                if (start) begin
                    state_next      = RUN;
                    vec_next        = '0;
                    settle_cnt_next = '0;
                    err_count_next  = '0;
                    ffv_next        = 1'b0;
                end
            end
            RUN: begin
                if (!sample) begin
                    settle_cnt_next = settle_cnt_reg + 8'd1;
                end else begin
                    if (mis_hit) begin
                        mismatch_next     = 1'b1;
                        mismatch_vec_next = vec_reg[N-1:0];
                        err_count_next    = err_count_reg + ONE_N1;
                        if (!ffv_reg) begin
                            ffv_next   = 1'b1;
                            ffvec_next = vec_reg[N-1:0];
                        end
                    end
                    // dut_in keeps the last applied vector once the sweep ends.
                    if ((vec_reg == LAST_VEC) || (STOP_ON_FAIL && mis_hit)) begin
                        state_next = DONE;
                    end else begin
                        vec_next        = vec_reg + ONE_N1;
                        settle_cnt_next = '0;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign dut_in           = vec_reg[N-1:0];
    assign busy             = (state_reg == RUN);
    assign done             = (state_reg == DONE);
    assign pass             = (state_reg == DONE) && (err_count_reg == '0);
    assign err_count        = err_count_reg;
    assign first_fail_valid = ffv_reg;
    assign first_fail_vec   = ffvec_reg;
    assign mismatch         = mismatch_reg;
    assign mismatch_vec     = mismatch_vec_reg;

endmodule

// File: tb/tb_tt_sweep_checker.sv
// Scenario bench for tt_sweep_checker: three checker instances (default, stop-on-fail,
// 4-input/2-output zero-settle) against behavioural DUT models, with a mismatch scoreboard.
module tb_tt_sweep_checker;

    localparam logic [31:0] EXP_C = 32'hB73C_9E51;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic start_a = 1'b0, start_b = 1'b0, start_c = 1'b0;
    int   mode_a = 0;

    logic [2:0] dut_in_a, ffvec_a, misvec_a;
    logic [0:0] dut_out_a;
    logic       busy_a, done_a, pass_a, ffv_a, mis_a;
    logic [3:0] err_a;

    logic [2:0] dut_in_b, ffvec_b, misvec_b;
    logic [0:0] dut_out_b;
    logic       busy_b, done_b, pass_b, ffv_b, mis_b;
    logic [3:0] err_b;

    logic [3:0] dut_in_c, ffvec_c, misvec_c;
    logic [1:0] dut_out_c;
    logic       busy_c, done_c, pass_c, ffv_c, mis_c;
    logic [4:0] err_c;
    logic [1:0] rand_out_c [16];

    int checks = 0;
    int errors = 0;
    int q_a[$];
    int q_b[$];
    int q_c[$];

    always #5 clk = ~clk;

    // Reference function y = ~a&~b&~c | a&~b&~c | a&~b&c with a as the MSB.
    function automatic logic spec_y(input logic [2:0] v);
        logic a, b, c;
        a = v[2]; b = v[1]; c = v[0];
        return (~a & ~b & ~c) | (a & ~b & ~c) | (a & ~b & c);
    endfunction

    // Behavioural DUT: 0 correct, 1 stuck at zero, 2 also drives 1 for vector 6.
    function automatic logic model_y(input int mode, input logic [2:0] v);
        case (mode)
            1:       return 1'b0;
            2:       return spec_y(v) | (v == 3'd6);
            default: return spec_y(v);
        endcase
    endfunction

    assign dut_out_a = model_y(mode_a, dut_in_a);
    assign dut_out_b = model_y(2, dut_in_b);
    assign dut_out_c = rand_out_c[dut_in_c];

    tt_sweep_checker u_a (
        .clk(clk), .reset_n(reset_n), .start(start_a),
        .dut_in(dut_in_a), .dut_out(dut_out_a), .busy(busy_a), .done(done_a),
        .pass(pass_a), .err_count(err_a), .first_fail_valid(ffv_a),
        .first_fail_vec(ffvec_a), .mismatch(mis_a), .mismatch_vec(misvec_a)
    );

    tt_sweep_checker #(.N(3), .M(1), .SETTLE(1), .EXPECTED(8'h31), .STOP_ON_FAIL(1'b1)) u_b (
        .clk(clk), .reset_n(reset_n), .start(start_b),
        .dut_in(dut_in_b), .dut_out(dut_out_b), .busy(busy_b), .done(done_b),
        .pass(pass_b), .err_count(err_b), .first_fail_valid(ffv_b),
        .first_fail_vec(ffvec_b), .mismatch(mis_b), .mismatch_vec(misvec_b)
    );

    tt_sweep_checker #(.N(4), .M(2), .SETTLE(0), .EXPECTED(EXP_C), .STOP_ON_FAIL(1'b0)) u_c (
        .clk(clk), .reset_n(reset_n), .start(start_c),
        .dut_in(dut_in_c), .dut_out(dut_out_c), .busy(busy_c), .done(done_c),
        .pass(pass_c), .err_count(err_c), .first_fail_valid(ffv_c),
        .first_fail_vec(ffvec_c), .mismatch(mis_c), .mismatch_vec(misvec_c)
    );

    // Scoreboard side: every mismatch pulse must match the next expected vector.
    always @(negedge clk) begin
        if (mis_a === 1'b1) begin
            checks++;
            if (q_a.size() == 0) begin
                errors++;
                $display("FAIL mon_a unexpected pulse: got vec %0d, required no pulse", misvec_a);
            end else if (misvec_a !== 3'(q_a[0])) begin
                errors++;
                $display("FAIL mon_a mismatch_vec: got %0d, required %0d", misvec_a, q_a[0]);
                void'(q_a.pop_front());
            end else begin
                $display("mon_a mismatch pulse vec %0d", misvec_a);
                void'(q_a.pop_front());
            end
        end
        if (mis_b === 1'b1) begin
            checks++;
            if (q_b.size() == 0) begin
                errors++;
                $display("FAIL mon_b unexpected pulse: got vec %0d, required no pulse", misvec_b);
            end else if (misvec_b !== 3'(q_b[0])) begin
                errors++;
                $display("FAIL mon_b mismatch_vec: got %0d, required %0d", misvec_b, q_b[0]);
                void'(q_b.pop_front());
            end else begin
                $display("mon_b mismatch pulse vec %0d", misvec_b);
                void'(q_b.pop_front());
            end
        end
        if (mis_c === 1'b1) begin
            checks++;
            if (q_c.size() == 0) begin
                errors++;
                $display("FAIL mon_c unexpected pulse: got vec %0d, required no pulse", misvec_c);
            end else if (misvec_c !== 4'(q_c[0])) begin
                errors++;
                $display("FAIL mon_c mismatch_vec: got %0d, required %0d", misvec_c, q_c[0]);
                void'(q_c.pop_front());
            end else begin
                $display("mon_c mismatch pulse vec %0d", misvec_c);
                void'(q_c.pop_front());
            end
        end
    end

    task automatic push_expected_a(input int mode);
        for (int v = 0; v < 8; v++)
            if (model_y(mode, 3'(v)) !== spec_y(3'(v))) q_a.push_back(v);
    endtask

    task automatic pulse_start_a();
        @(posedge clk); #1 start_a = 1'b1;
        @(posedge clk); #1 start_a = 1'b0;
    endtask

    // Runs from the first RUN cycle until done; reports cycle count and dut_in stepping errors.
    task automatic wait_done_a(output int cyc, output int bad);
        cyc = 0; bad = 0;
        while (done_a !== 1'b1 && cyc < 200) begin
            if (dut_in_a !== 3'(cyc / 2)) bad++;
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({dut_in_a, busy_a, done_a, pass_a, err_a, ffv_a, ffvec_a, mis_a, misvec_a} !== '0) begin
            errors++;
            $display("FAIL reset_a outputs: got %h, required 0",
                     {dut_in_a, busy_a, done_a, pass_a, err_a, ffv_a, ffvec_a, mis_a, misvec_a});
        end
        checks++;
        if ({dut_in_b, busy_b, done_b, pass_b, err_b, ffv_b, ffvec_b, mis_b, misvec_b} !== '0) begin
            errors++;
            $display("FAIL reset_b outputs: got %h, required 0",
                     {dut_in_b, busy_b, done_b, pass_b, err_b, ffv_b, ffvec_b, mis_b, misvec_b});
        end
        checks++;
        if ({dut_in_c, busy_c, done_c, pass_c, err_c, ffv_c, ffvec_c, mis_c, misvec_c} !== '0) begin
            errors++;
            $display("FAIL reset_c outputs: got %h, required 0",
                     {dut_in_c, busy_c, done_c, pass_c, err_c, ffv_c, ffvec_c, mis_c, misvec_c});
        end
        $display("test_reset done");
        reset_n = 1'b1;
    endtask

    task automatic test_correct_sweep();
        int cyc, bad;
        mode_a = 0;
        push_expected_a(mode_a);
        pulse_start_a();
        checks++;
        if (busy_a !== 1'b1) begin errors++; $display("FAIL correct busy: got %b, required 1", busy_a); end
        wait_done_a(cyc, bad);
        checks++;
        if (cyc !== 16) begin errors++; $display("FAIL correct latency: got %0d, required 16", cyc); end
        checks++;
        if (bad !== 0) begin errors++; $display("FAIL correct dut_in steps: got %0d bad, required 0", bad); end
        checks++;
        if ({pass_a, busy_a, err_a, ffv_a} !== {1'b1, 1'b0, 4'd0, 1'b0}) begin
            errors++;
            $display("FAIL correct summary: got pass=%b busy=%b err=%0d ffv=%b, required 1 0 0 0",
                     pass_a, busy_a, err_a, ffv_a);
        end
        @(negedge clk); #1;
        checks++;
        if (q_a.size() !== 0) begin errors++; $display("FAIL correct queue: got %0d left, required 0", q_a.size()); end
        $display("test_correct_sweep cycles=%0d err=%0d pass=%b", cyc, err_a, pass_a);
    endtask

    task automatic test_stuck_zero();
        int cyc, bad;
        mode_a = 1;
        push_expected_a(mode_a);
        pulse_start_a();
        wait_done_a(cyc, bad);
        checks++;
        if (cyc !== 16) begin errors++; $display("FAIL stuck latency: got %0d, required 16", cyc); end
        checks++;
        if ({err_a, ffv_a, ffvec_a, pass_a} !== {4'd3, 1'b1, 3'd0, 1'b0}) begin
            errors++;
            $display("FAIL stuck summary: got err=%0d ffv=%b ffvec=%0d pass=%b, required 3 1 0 0",
                     err_a, ffv_a, ffvec_a, pass_a);
        end
        @(negedge clk); #1;
        checks++;
        if (q_a.size() !== 0) begin errors++; $display("FAIL stuck queue: got %0d left, required 0", q_a.size()); end
        $display("test_stuck_zero err=%0d first=%0d", err_a, ffvec_a);
    endtask

    task automatic test_extra_one();
        int cyc, bad;
        mode_a = 2;
        push_expected_a(mode_a);
        pulse_start_a();
        wait_done_a(cyc, bad);
        checks++;
        if ({err_a, ffv_a, ffvec_a, pass_a} !== {4'd1, 1'b1, 3'd6, 1'b0}) begin
            errors++;
            $display("FAIL extra summary: got err=%0d ffv=%b ffvec=%0d pass=%b, required 1 1 6 0",
                     err_a, ffv_a, ffvec_a, pass_a);
        end
        @(negedge clk); #1;
        checks++;
        if (q_a.size() !== 0) begin errors++; $display("FAIL extra queue: got %0d left, required 0", q_a.size()); end
        $display("test_extra_one err=%0d first=%0d", err_a, ffvec_a);
    endtask

    task automatic test_stop_on_fail();
        int cyc, bad;
        q_b.push_back(6);
        @(posedge clk); #1 start_b = 1'b1;
        @(posedge clk); #1 start_b = 1'b0;
        cyc = 0; bad = 0;
        while (done_b !== 1'b1 && cyc < 200) begin
            if (dut_in_b !== 3'(cyc / 2)) bad++;
            @(posedge clk); #1;
            cyc++;
        end
        checks++;
        if (cyc !== 14) begin errors++; $display("FAIL stop latency: got %0d, required 14", cyc); end
        checks++;
        if (bad !== 0) begin errors++; $display("FAIL stop dut_in steps: got %0d bad, required 0", bad); end
        checks++;
        if ({dut_in_b, err_b, ffvec_b, pass_b, busy_b} !== {3'd6, 4'd1, 3'd6, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL stop summary: got dut_in=%0d err=%0d ffvec=%0d pass=%b busy=%b, required 6 1 6 0 0",
                     dut_in_b, err_b, ffvec_b, pass_b, busy_b);
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({done_b, dut_in_b} !== {1'b1, 3'd6}) begin
            errors++;
            $display("FAIL stop hold: got done=%b dut_in=%0d, required 1 6", done_b, dut_in_b);
        end
        checks++;
        if (q_b.size() !== 0) begin errors++; $display("FAIL stop queue: got %0d left, required 0", q_b.size()); end
        $display("test_stop_on_fail cycles=%0d dut_in=%0d err=%0d", cyc, dut_in_b, err_b);
    endtask

    task automatic test_reset_mid_sweep();
        int cyc, bad, guard;
        mode_a = 0;
        pulse_start_a();
        guard = 0;
        while (dut_in_a !== 3'd3 && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        checks++;
        if (dut_in_a !== 3'd3) begin errors++; $display("FAIL midreset reach vec3: got %0d, required 3", dut_in_a); end
        reset_n = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        checks++;
        if ({dut_in_a, busy_a, done_a, pass_a, err_a, ffv_a, ffvec_a, mis_a, misvec_a} !== '0) begin
            errors++;
            $display("FAIL midreset outputs: got %h, required 0",
                     {dut_in_a, busy_a, done_a, pass_a, err_a, ffv_a, ffvec_a, mis_a, misvec_a});
        end
        push_expected_a(mode_a);
        pulse_start_a();
        wait_done_a(cyc, bad);
        checks++;
        if ({cyc == 16, bad == 0, pass_a, err_a, ffv_a} !== {1'b1, 1'b1, 1'b1, 4'd0, 1'b0}) begin
            errors++;
            $display("FAIL midreset resweep: got cyc=%0d bad=%0d pass=%b err=%0d ffv=%b, required 16 0 1 0 0",
                     cyc, bad, pass_a, err_a, ffv_a);
        end
        $display("test_reset_mid_sweep cycles=%0d pass=%b", cyc, pass_a);
    endtask

    task automatic test_back_to_back();
        int cyc, bad;
        mode_a = 1;
        push_expected_a(mode_a);
        push_expected_a(mode_a);
        @(posedge clk); #1 start_a = 1'b1;
        @(posedge clk); #1;
        wait_done_a(cyc, bad);
        checks++;
        if ({cyc == 16, bad == 0, err_a} !== {1'b1, 1'b1, 4'd3}) begin
            errors++;
            $display("FAIL b2b held start: got cyc=%0d bad=%0d err=%0d, required 16 0 3", cyc, bad, err_a);
        end
        @(posedge clk); #1;
        checks++;
        if ({done_a, busy_a, err_a, dut_in_a, ffv_a} !== {1'b0, 1'b1, 4'd0, 3'd0, 1'b0}) begin
            errors++;
            $display("FAIL b2b restart: got done=%b busy=%b err=%0d dut_in=%0d ffv=%b, required 0 1 0 0 0",
                     done_a, busy_a, err_a, dut_in_a, ffv_a);
        end
        start_a = 1'b0;
        wait_done_a(cyc, bad);
        checks++;
        if ({cyc == 16, bad == 0, err_a, pass_a} !== {1'b1, 1'b1, 4'd3, 1'b0}) begin
            errors++;
            $display("FAIL b2b second sweep: got cyc=%0d bad=%0d err=%0d pass=%b, required 16 0 3 0",
                     cyc, bad, err_a, pass_a);
        end
        @(negedge clk); #1;
        checks++;
        if (q_a.size() !== 0) begin errors++; $display("FAIL b2b queue: got %0d left, required 0", q_a.size()); end
        $display("test_back_to_back err=%0d", err_a);
    endtask

    task automatic test_random_table();
        int cyc, bad, exp_err, exp_first;
        logic [1:0] e;
        exp_err = 0; exp_first = -1;
        for (int v = 0; v < 16; v++) begin
            e = EXP_C[v*2 +: 2];
            rand_out_c[v] = ($urandom_range(0, 1) == 1) ? e : 2'($urandom_range(0, 3));
        end
        e = EXP_C[9*2 +: 2];
        rand_out_c[9] = e ^ 2'b01;
        for (int v = 0; v < 16; v++) begin
            e = EXP_C[v*2 +: 2];
            if (rand_out_c[v] !== e) begin
                exp_err++;
                if (exp_first < 0) exp_first = v;
                q_c.push_back(v);
            end
        end
        @(posedge clk); #1 start_c = 1'b1;
        @(posedge clk); #1 start_c = 1'b0;
        cyc = 0; bad = 0;
        while (done_c !== 1'b1 && cyc < 200) begin
            if (dut_in_c !== 4'(cyc)) bad++;
            @(posedge clk); #1;
            cyc++;
        end
        checks++;
        if (cyc !== 16) begin errors++; $display("FAIL random latency: got %0d, required 16", cyc); end
        checks++;
        if (bad !== 0) begin errors++; $display("FAIL random dut_in steps: got %0d bad, required 0", bad); end
        checks++;
        if ({err_c, ffv_c, ffvec_c, pass_c} !== {5'(exp_err), 1'b1, 4'(exp_first), 1'b0}) begin
            errors++;
            $display("FAIL random summary: got err=%0d ffv=%b ffvec=%0d pass=%b, required %0d 1 %0d 0",
                     err_c, ffv_c, ffvec_c, pass_c, exp_err, exp_first);
        end
        @(negedge clk); #1;
        checks++;
        if (q_c.size() !== 0) begin errors++; $display("FAIL random queue: got %0d left, required 0", q_c.size()); end
        $display("test_random_table err=%0d expected=%0d first=%0d", err_c, exp_err, exp_first);
    endtask

    initial begin
        for (int v = 0; v < 16; v++) rand_out_c[v] = 2'b00;
        test_reset();
        test_correct_sweep();
        test_stuck_zero();
        test_extra_one();
        test_stop_on_fail();
        test_reset_mid_sweep();
        test_back_to_back();
        test_random_table();
        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
